trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Trap initiator for the machine-mode CSR file. It collects synchronous exceptions from the pipeline and the three machine interrupt sources, then prioritises them and gates them by privilege and enables.
- For each taken trap it issues a single-cycle context-switch request (CS, CAUSE, NPC) to the CSR file. It stalls the pipeline until the CSR file acknowledges, then flushes.
- It sits between the execute/writeback stages and the CSR file, on the opposite side of the CS/CAUSE/NPC interface.

Parameters:
- XLEN, 64, data/PC width.
- ACK_TIMEOUT, 15, maximum cycles WAIT_ACK waits for CS_ACK before aborting; legal range 1..255.
- SYNC_STAGES, 2, synchroniser depth for the asynchronous IRQ_EXT input.

Ports:
- CLK  in  1  core clock.
- RESET_N  in  1  asynchronous active-low reset.
- EXC_VALID  in  1  pipeline reports a synchronous exception this cycle.
- EXC_CODE  in  5  exception code (0..15, RISC-V mcause encoding).
- EXC_PC  in  XLEN  PC of the faulting instruction.
- NPC  in  XLEN  PC of the next instruction to execute; saved when an interrupt is taken.
- IRQ_EXT  in  1  external interrupt, level, asynchronous.
- IRQ_TIMER  in  1  timer interrupt, level, synchronous to CLK.
- IRQ_SW  in  1  software interrupt, level, synchronous to CLK.
- MSTATUS_MIE  in  1  global machine interrupt enable, from the CSR file.
- MIE  in  XLEN  per-source interrupt enables; bits 3, 7 and 11 are used.
- PRIVILEGE  in  2  current privilege level, from the CSR file.
- RET_VALID  in  1  xRET retiring this cycle.
- CS  out  1  context-switch request pulse to the CSR file.
- CAUSE  out  XLEN  trap cause; valid while CS=1.
- TRAP_PC  out  XLEN  PC to be saved in xEPC; valid while CS=1.
- CS_ACK  in  1  single-cycle acknowledge from the CSR file; the trap PC is loaded.
- STALL  out  1  freeze fetch/decode/execute.
- FLUSH  out  1  kill all in-flight instructions.
- MIP  out  XLEN  pending bits (3 MSIP, 7 MTIP, 11 MEIP); all other bits 0.
- TRAP_ERR  out  1  sticky flag; an acknowledge timeout occurred.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - Outputs: CS=0, CAUSE=0, TRAP_PC=0, STALL=0, FLUSH=0, MIP=0, TRAP_ERR=0.
  - Internal state: FSM=IDLE, synchroniser flops=0, timeout counter=0.
  - Reset mid-handshake abandons the trap with no further CS.
- MIP:
  - MIP[11] is IRQ_EXT after SYNC_STAGES flops.
  - MIP[7] and MIP[3] are IRQ_TIMER and IRQ_SW, each registered once.
  - Pending bits are level-sensitive and never latched: deasserting a source before the trap is taken cancels it.
- Interrupt global enable: GIE = (PRIVILEGE != 2'b11) | MSTATUS_MIE.
- Interrupt candidate: any of MIP[i] & MIE[i] for i in {11, 3, 7}, with GIE=1.
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Exception vs interrupt: an exception has priority over interrupts in the same cycle.
- FSM states IDLE, REQ, WAIT_ACK, FLUSH:
  - IDLE:
    - If EXC_VALID=1: latch CAUSE={59'b0,EXC_CODE} and TRAP_PC=EXC_PC, set STALL=1, go to REQ.
    - Else if an interrupt candidate exists and RET_VALID=0: latch CAUSE={1'b1,55'b0,code} and TRAP_PC=NPC, set STALL=1, go to REQ.
    - RET_VALID=1 suppresses interrupt entry for that cycle only; exceptions are still taken.
  - REQ: CS=1 for exactly one cycle; clear the counter; go to WAIT_ACK.
  - WAIT_ACK:
    - CS=0 and STALL=1.
    - On CS_ACK=1, go to FLUSH.
    - Otherwise increment the counter. When it reaches ACK_TIMEOUT, set TRAP_ERR=1, clear STALL and go to IDLE with no flush.
  - FLUSH: FLUSH=1 and STALL=1 for one cycle, then go to IDLE with STALL=0.
- Latency: EXC_VALID sampled in cycle N gives CS=1 in cycle N+1. The earliest FLUSH is N+3, when CS_ACK arrives in N+2.
- Capture timing: CAUSE and TRAP_PC are captured on the IDLE->REQ edge and held stable until the next capture.
- Events while busy: EXC_VALID and interrupts are ignored outside IDLE, since the pipeline is stalled. A CS_ACK outside WAIT_ACK is ignored.
- Back-to-back traps: a pending interrupt still enabled after FLUSH is taken from IDLE on the following cycle, so the minimum trap spacing is 4 cycles.
- TRAP_ERR clears only on reset.

Decomposition:
- Shared package trap_pkg holds:
  - FSM state encoding.
  - Interrupt cause codes IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11.
  - Bit position of the interrupt flag in CAUSE (XLEN-1).
  - Privilege constant PRIV_M=2'b11.
- One sub-module, irq_sync: a SYNC_STAGES-deep flop chain with async active-low reset, used for IRQ_EXT.

Test Plan:
- Exception path:
  - Stimulus: in M-mode, EXC_VALID=1, EXC_CODE=2, EXC_PC=0x8000_0010; CS_ACK 2 cycles after CS.
  - Required: CS=1 one cycle later, CAUSE=0x2, TRAP_PC=0x8000_0010; FLUSH one cycle after CS_ACK.
- Interrupt priority:
  - Stimulus: PRIVILEGE=0, MIE bits 3/7/11 set, IRQ_TIMER=1 and IRQ_SW=1, IRQ_EXT=0.
  - Required: CAUSE=0x8000_0000_0000_0003, TRAP_PC=NPC. After ack and flush, with IRQ_SW dropped, the next CAUSE=0x8000_0000_0000_0007.
- Gating:
  - Stimulus: PRIVILEGE=3, MSTATUS_MIE=0, IRQ_TIMER=1.
  - Required: no CS for 20 cycles. Setting MSTATUS_MIE=1 gives CS within 2 cycles with CAUSE=…0007.
- Simultaneous events:
  - Stimulus: EXC_VALID (code 11) and MIP[11] enabled in the same cycle.
  - Required: CAUSE=0xB, interrupt bit 0. The interrupt is taken after FLUSH.
- Timeout:
  - Stimulus: never send CS_ACK.
  - Required: after ACK_TIMEOUT=15 cycles, TRAP_ERR=1, STALL=0, no FLUSH.
  - Required: a CS_ACK pulse later has no effect.
- Async reset:
  - Stimulus: deassert RESET_N in WAIT_ACK, mid-cycle.
  - Required: STALL, CS and MIP go to 0 immediately, without waiting for a clock edge; the FSM is back in IDLE after release.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap initiator.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_FLUSH    = 2'd3
  } trap_state_t;

  // mcause interrupt codes for the three machine interrupt sources
  localparam int unsigned IRQ_MSI = 3;
  localparam int unsigned IRQ_MTI = 7;
  localparam int unsigned IRQ_MEI = 11;

  localparam logic [1:0] PRIV_M = 2'b11;

  // Position of the interrupt flag in CAUSE for a given register width
  function automatic int unsigned cause_irq_bit(input int unsigned xlen);
    return xlen - 1;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-flop synchroniser for a single asynchronous level input.
module irq_sync
  import trap_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic irq_in,
  output logic irq_out
);

  logic [STAGES-1:0] sync_ff;

  // Shift the raw level through the chain; the last stage is the safe copy
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_ff <= '0;
    end else begin
      sync_ff[0] <= irq_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        sync_ff[i] <= sync_ff[i-1];
      end
    end
  end

  assign irq_out = sync_ff[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap initiator: picks the highest-priority exception or enabled interrupt,
// issues a one-cycle context-switch request to the CSR file, stalls until the
// acknowledge and then flushes the pipeline.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no trap in progress; sample exceptions / interrupts
// REQ      | CS pulse with CAUSE / TRAP_PC; pipeline stalled
// WAIT_ACK | stalled, waiting for CS_ACK; give up after ACK_TIMEOUT
// FLUSH    | one-cycle flush of in-flight instructions, then IDLE
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            EXC_VALID,
  input  logic [4:0]      EXC_CODE,
  input  logic [XLEN-1:0] EXC_PC,
  input  logic [XLEN-1:0] NPC,
  input  logic            IRQ_EXT,
  input  logic            IRQ_TIMER,
  input  logic            IRQ_SW,
  input  logic            MSTATUS_MIE,
  input  logic [XLEN-1:0] MIE,
  input  logic [1:0]      PRIVILEGE,
  input  logic            RET_VALID,
  output logic            CS,
  output logic [XLEN-1:0] CAUSE,
  output logic [XLEN-1:0] TRAP_PC,
  input  logic            CS_ACK,
  output logic            STALL,
  output logic            FLUSH,
  output logic [XLEN-1:0] MIP,
  output logic            TRAP_ERR
);

  localparam int unsigned IRQ_BIT = cause_irq_bit(XLEN);
  localparam logic [7:0]  ACK_TC  = 8'(ACK_TIMEOUT);

  trap_state_t     state_q, state_d;
  logic [7:0]      ack_cnt_q, ack_cnt_d;
  logic            meip, mtip_q, msip_q;
  logic            gie, irq_any, capture, set_err;
  logic [XLEN-1:0] irq_cause, cause_q, trap_pc_q;
  logic            trap_err_q;
  logic            cs_o, stall_o, flush_o;

  // Only bits 3/7/11 of MIE matter; the rest are deliberately ignored
  logic unused_mie;
  assign unused_mie = ^MIE;

  irq_sync #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .irq_in  (IRQ_EXT),
    .irq_out (meip)
  );

  // Timer and software sources are already on CLK; one register stage each
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      mtip_q <= IRQ_TIMER;
      msip_q <= IRQ_SW;
    end
  end

  // Pending view for the CSR file; pure level, nothing is latched here
  always_comb begin
    MIP          = '0;
    MIP[IRQ_MEI] = meip;
    MIP[IRQ_MTI] = mtip_q;
    MIP[IRQ_MSI] = msip_q;
  end

  // Enabled interrupt selection, MEI > MSI > MTI
  always_comb begin
    gie                = (PRIVILEGE != PRIV_M) | MSTATUS_MIE;
    irq_any            = 1'b0;
    irq_cause          = '0;
    irq_cause[IRQ_BIT] = 1'b1;
    if (gie) begin
      if (meip & MIE[IRQ_MEI]) begin
        irq_any         = 1'b1;
        irq_cause[3:0]  = 4'(IRQ_MEI);
      end else if (msip_q & MIE[IRQ_MSI]) begin
        irq_any         = 1'b1;
        irq_cause[3:0]  = 4'(IRQ_MSI);
      end else if (mtip_q & MIE[IRQ_MTI]) begin
        irq_any         = 1'b1;
        irq_cause[3:0]  = 4'(IRQ_MTI);
      end
    end
  end

  // State and acknowledge-timeout counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      ack_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
    end
  end

  // Next state and Moore outputs; exceptions win over interrupts
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    capture   = 1'b0;
    set_err   = 1'b0;
    cs_o      = 1'b0;
    stall_o   = 1'b0;
    flush_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (EXC_VALID || (irq_any && !RET_VALID)) begin
          capture = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        cs_o      = 1'b1;
        stall_o   = 1'b1;
        ack_cnt_d = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        stall_o = 1'b1;
        if (CS_ACK) begin
          state_d = ST_FLUSH;
        end else begin
          ack_cnt_d = ack_cnt_q + 8'd1;
          if (ack_cnt_q + 8'd1 == ACK_TC) begin
            set_err = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Trap context is captured only when leaving IDLE and held until the next trap
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cause_q   <= '0;
      trap_pc_q <= '0;
    end else if (capture) begin
      if (EXC_VALID) begin
        cause_q   <= {{(XLEN-5){1'b0}}, EXC_CODE};
        trap_pc_q <= EXC_PC;
      end else begin
        cause_q   <= irq_cause;
        trap_pc_q <= NPC;
      end
    end
  end

  // Sticky acknowledge-timeout flag, cleared only by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      trap_err_q <= 1'b0;
    end else if (set_err) begin
      trap_err_q <= 1'b1;
    end
  end

  assign CS       = cs_o;
  assign STALL    = stall_o;
  assign FLUSH    = flush_o;
  assign CAUSE    = cause_q;
  assign TRAP_PC  = trap_pc_q;
  assign TRAP_ERR = trap_err_q;

endmodule
